// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes and initiator state encoding
package axi_lite_pkg;

    localparam logic [1:0] AXI_OK  = 2'b00;
    localparam logic [1:0] AXI_ERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } axi_lite_init_state_t;

endpackage

// File: rtl/axi_lite_initiator.sv
// rtl/axi_lite_initiator.sv - single-outstanding AXI-Lite initiator driven by a cmd/rsp handshake
module axi_lite_initiator
    import axi_lite_pkg::*;
#(
    parameter int AXI_LITE_ADDR_WIDTH = 8
) (
    input  logic                           aclk,
    input  logic                           areset,

    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                    cmd_wdata,

    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_write,
    output logic [31:0]                    rsp_rdata,
    output logic [1:0]                     rsp_resp,

    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_awaddr,
    output logic                           m_axi_lite_awvalid,
    input  logic                           m_axi_lite_awready,
    output logic [31:0]                    m_axi_lite_wdata,
    output logic                           m_axi_lite_wvalid,
    input  logic                           m_axi_lite_wready,
    input  logic [1:0]                     m_axi_lite_bresp,
    input  logic                           m_axi_lite_bvalid,
    output logic                           m_axi_lite_bready,
    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_araddr,
    output logic                           m_axi_lite_arvalid,
    input  logic                           m_axi_lite_arready,
    input  logic [31:0]                    m_axi_lite_rdata,
    input  logic [1:0]                     m_axi_lite_rresp,
    input  logic                           m_axi_lite_rvalid,
    output logic                           m_axi_lite_rready
);

    axi_lite_init_state_t state_q, state_d;

    // aw_pend/w_pend are the AW/W VALID registers themselves, so each channel drops independently
    logic                           aw_pend_q, aw_pend_d;
    logic                           w_pend_q, w_pend_d;
    logic                           arvalid_q, arvalid_d;
    logic                           bready_q, bready_d;
    logic                           rready_q, rready_d;
    logic [AXI_LITE_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_LITE_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [31:0]                    wdata_q, wdata_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic                           rsp_write_q, rsp_write_d;
    logic [31:0]                    rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                     rsp_resp_q, rsp_resp_d;

    always_comb begin
        state_d     = state_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_REQ: begin
                if (aw_pend_q && m_axi_lite_awready) aw_pend_d = 1'b0;
                if (w_pend_q && m_axi_lite_wready)   w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready_q && m_axi_lite_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = 32'd0;
                    rsp_resp_d  = m_axi_lite_bresp;
                    state_d     = DONE;
                end
            end
            RD_ADDR: begin
                if (m_axi_lite_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready_q && m_axi_lite_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axi_lite_rdata;
                    rsp_resp_d  = m_axi_lite_rresp;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // reset abandons any in-flight transaction; the responder is reset alongside
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_resp_q  <= AXI_OK;
        end else begin
            state_q     <= state_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready          = (state_q == IDLE);
    assign rsp_valid          = rsp_valid_q;
    assign rsp_write          = rsp_write_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign rsp_resp           = rsp_resp_q;
    assign m_axi_lite_awaddr  = awaddr_q;
    assign m_axi_lite_awvalid = aw_pend_q;
    assign m_axi_lite_wdata   = wdata_q;
    assign m_axi_lite_wvalid  = w_pend_q;
    assign m_axi_lite_bready  = bready_q;
    assign m_axi_lite_araddr  = araddr_q;
    assign m_axi_lite_arvalid = arvalid_q;
    assign m_axi_lite_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// tb/tb_axi_lite_initiator.sv - randomized self-checking bench with a behavioural responder and reference model
module tb_axi_lite_initiator;
    import axi_lite_pkg::*;

    localparam int AW = 8;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = 32'd0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   wdata, rdata;
    logic [1:0]    bresp, rresp;

    always #5 aclk = ~aclk;

    axi_lite_initiator #(.AXI_LITE_ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
        .m_axi_lite_wdata(wdata), .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
        .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
        .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
        .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
        .m_axi_lite_rready(rready)
    );

    // behavioural responder: 8-word register file with programmable handshake delays
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
    logic [1:0]  bresp_cfg = AXI_OK, rresp_cfg = AXI_OK;
    logic        stray_rvalid = 1'b0;
    logic [31:0] stray_rdata = 32'd0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend, bvalid_q, rvalid_q;
    logic [AW-1:0] st_awaddr;
    logic [31:0] st_wdata, rdata_q, r_hold;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] stub_mem [8];
    logic        wr_both;
    logic [AW-1:0] wr_addr_eff;
    logic [31:0] wr_data_eff;

    assign awready     = awvalid && (aw_cnt >= aw_dly);
    assign wready      = wvalid && (w_cnt >= w_dly);
    assign arready     = arvalid && (ar_cnt >= ar_dly);
    assign bvalid      = bvalid_q;
    assign bresp       = bresp_q;
    assign rvalid      = rvalid_q | stray_rvalid;
    assign rdata       = stray_rvalid ? stray_rdata : rdata_q;
    assign rresp       = rresp_q;
    assign wr_both     = (aw_got | (awvalid & awready)) & (w_got | (wvalid & wready));
    assign wr_addr_eff = aw_got ? st_awaddr : awaddr;
    assign wr_data_eff = w_got ? st_wdata : wdata;

    initial for (int i = 0; i < 8; i++) stub_mem[i] = 32'd0;

    always @(posedge aclk) begin
        if (areset) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            bvalid_q <= 1'b0; rvalid_q <= 1'b0; rdata_q <= 32'd0;
            bresp_q <= 2'b00; rresp_q <= 2'b00;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (awvalid && awready) begin aw_got <= 1'b1; st_awaddr <= awaddr; end
            if (wvalid && wready) begin w_got <= 1'b1; st_wdata <= wdata; end
            if (wr_both && !b_pend && !bvalid_q) begin
                stub_mem[wr_addr_eff[4:2]] <= wr_data_eff;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (b_dly == 0) begin bvalid_q <= 1'b1; bresp_q <= bresp_cfg; end
                else begin b_pend <= 1'b1; b_cnt <= b_dly - 1; end
            end
            if (b_pend) begin
                if (b_cnt == 0) begin b_pend <= 1'b0; bvalid_q <= 1'b1; bresp_q <= bresp_cfg; end
                else b_cnt <= b_cnt - 1;
            end
            if (bvalid_q && bready) bvalid_q <= 1'b0;
            if (arvalid && arready) begin
                if (r_dly == 0) begin
                    rvalid_q <= 1'b1; rdata_q <= stub_mem[araddr[4:2]]; rresp_q <= rresp_cfg;
                end else begin
                    r_pend <= 1'b1; r_cnt <= r_dly - 1; r_hold <= stub_mem[araddr[4:2]];
                end
            end
            if (r_pend) begin
                if (r_cnt == 0) begin
                    r_pend <= 1'b0; rvalid_q <= 1'b1; rdata_q <= r_hold; rresp_q <= rresp_cfg;
                end else r_cnt <= r_cnt - 1;
            end
            if (rvalid_q && rready) rvalid_q <= 1'b0;
        end
    end

    // bus monitor: handshake/valid-cycle counters and VALID/payload stability violations
    int aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs = 0, r_hs = 0, bready_rise = 0, prot_err = 0;
    logic bready_prev = 1'b0, aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
    logic [AW-1:0] aw_ref, ar_ref;
    logic [31:0] w_ref;

    always @(posedge aclk) begin
        aw_hi <= aw_hi + (awvalid ? 1 : 0);
        w_hi  <= w_hi + (wvalid ? 1 : 0);
        ar_hi <= ar_hi + (arvalid ? 1 : 0);
        b_hs  <= b_hs + ((bvalid && bready) ? 1 : 0);
        r_hs  <= r_hs + ((rvalid && rready) ? 1 : 0);
        bready_rise <= bready_rise + ((bready && !bready_prev) ? 1 : 0);
        bready_prev <= bready;
        prot_err <= prot_err
                    + ((aw_hold && (!awvalid || awaddr !== aw_ref)) ? 1 : 0)
                    + ((w_hold && (!wvalid || wdata !== w_ref)) ? 1 : 0)
                    + ((ar_hold && (!arvalid || araddr !== ar_ref)) ? 1 : 0)
                    + ((!areset && (bready && rready)) ? 1 : 0);
        aw_hold <= awvalid && !awready && !areset;
        w_hold  <= wvalid && !wready && !areset;
        ar_hold <= arvalid && !arready && !areset;
        aw_ref <= awaddr; w_ref <= wdata; ar_ref <= araddr;
    end

    int n_vec = 0, n_miss = 0;
    logic [31:0] model_mem [8];
    time t_acc, t_prev;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // issue one command, hold rsp_ready low for 'hold' cycles while poking a rival command
    task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                          input int hold, output time acc);
        int s_aw, s_w, s_ar, s_b, s_r, s_br, s_pe, cyc, exp_lat;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic busy_bad, hold_bad;
        exp_rdata = wr ? 32'd0 : model_mem[addr[4:2]];
        exp_resp  = wr ? bresp_cfg : rresp_cfg;
        exp_lat   = wr ? 3 + max2(aw_dly, w_dly) + b_dly : 3 + ar_dly + r_dly;
        if (wr) model_mem[addr[4:2]] = data;
        s_aw = aw_hi; s_w = w_hi; s_ar = ar_hi; s_b = b_hs; s_r = r_hs; s_br = bready_rise; s_pe = prot_err;
        busy_bad = 1'b0; hold_bad = 1'b0;

        check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        @(posedge aclk); acc = $time; #1;
        cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = AW'($urandom);
        check_eq("req_valids", 64'({awvalid, wvalid, arvalid}), wr ? 64'b110 : 64'b001);
        check_eq("req_addr", 64'(wr ? awaddr : araddr), 64'(addr));
        if (wr) check_eq("req_wdata", 64'(wdata), 64'(data));

        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            if (cmd_ready) busy_bad = 1'b1;
            @(posedge aclk); #1; cyc++;
        end
        check_eq("latency", 64'(cyc + 1), 64'(exp_lat));
        check_eq("rsp_write", 64'(rsp_write), 64'(wr));
        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        check_eq("rsp_resp", 64'(rsp_resp), 64'(exp_resp));

        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_write = $urandom_range(0, 1) == 1;
            @(posedge aclk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_resp !== exp_resp || cmd_ready !== 1'b0)
                hold_bad = 1'b1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge aclk); #1;
        rsp_ready = 1'b0;
        check_eq("rsp_valid_cleared", 64'(rsp_valid), 64'd0);
        check_eq("cmd_ready_after", 64'(cmd_ready), 64'd1);
        check_eq("busy_cmd_ready", 64'(busy_bad), 64'd0);
        check_eq("hold_stable", 64'(hold_bad), 64'd0);
        check_eq("protocol_errs", 64'(prot_err - s_pe), 64'd0);
        if (wr) begin
            check_eq("awvalid_cycles", 64'(aw_hi - s_aw), 64'(aw_dly + 1));
            check_eq("wvalid_cycles", 64'(w_hi - s_w), 64'(w_dly + 1));
            check_eq("b_handshakes", 64'(b_hs - s_b), 64'd1);
            check_eq("wr_resp_entries", 64'(bready_rise - s_br), 64'd1);
            check_eq("no_ar", 64'(ar_hi - s_ar), 64'd0);
        end else begin
            check_eq("arvalid_cycles", 64'(ar_hi - s_ar), 64'(ar_dly + 1));
            check_eq("r_handshakes", 64'(r_hs - s_r), 64'd1);
            check_eq("no_aw", 64'(aw_hi - s_aw), 64'd0);
        end
    endtask

    task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin
        logic bad;
        int cyc;
        for (int i = 0; i < 8; i++) model_mem[i] = 32'd0;
        repeat (2) @(posedge aclk);
        #1;
        check_eq("reset_ctrl", 64'({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write}),
                 64'b1000_0000);
        check_eq("reset_payload", 64'({awaddr, araddr, wdata}), 64'd0);
        check_eq("reset_rsp", 64'({rsp_rdata, rsp_resp}), 64'd0);
        areset = 1'b0;
        @(posedge aclk); #1;

        // write then read back
        do_cmd(1'b1, 8'h04, 32'hDEADBEEF, 0, t_acc);
        do_cmd(1'b0, 8'h04, 32'h0, 0, t_acc);

        // skewed handshakes: AW late, W late, both together, with SLVERR
        set_dly(3, 0, 0, 0, 0);
        do_cmd(1'b1, 8'h08, 32'hA5A5_0001, 0, t_acc);
        set_dly(0, 3, 0, 0, 0);
        bresp_cfg = AXI_ERR;
        do_cmd(1'b1, 8'h0C, 32'hA5A5_0002, 0, t_acc);
        set_dly(2, 2, 1, 0, 0);
        do_cmd(1'b1, 8'h10, 32'hA5A5_0003, 0, t_acc);
        bresp_cfg = AXI_OK;
        set_dly(0, 0, 0, 0, 0);

        // long response stall on a read
        do_cmd(1'b1, 8'h14, 32'h12345678, 0, t_acc);
        do_cmd(1'b0, 8'h14, 32'h0, 5, t_acc);

        // reset while waiting for read data, then a stray rvalid
        set_dly(0, 0, 0, 0, 6);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h18;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (!rready && cyc < 20) begin @(posedge aclk); #1; cyc++; end
        check_eq("rd_data_reached", 64'(rready), 64'd1);
        areset = 1'b1;
        @(posedge aclk); #1;
        check_eq("mid_reset_state", 64'({rready, rsp_valid, cmd_ready, arvalid}), 64'b0010);
        areset = 1'b0;
        set_dly(0, 0, 0, 0, 0);
        stray_rvalid = 1'b1; stray_rdata = 32'hBAD0_BAD0;
        bad = 1'b0;
        repeat (3) begin
            @(posedge aclk); #1;
            if (rsp_valid !== 1'b0 || rready !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
        end
        stray_rvalid = 1'b0;
        check_eq("stray_rvalid_ignored", 64'(bad), 64'd0);

        // back-to-back writes then reads over the whole register file
        for (int i = 0; i < 8; i++) begin
            t_prev = t_acc;
            do_cmd(1'b1, AW'(i * 4), 32'(i) * 32'h11111111, 0, t_acc);
            if (i > 0) check_eq("b2b_write_period", 64'(t_acc - t_prev), 64'd40);
        end
        for (int i = 0; i < 8; i++) do_cmd(1'b0, AW'(i * 4), 32'h0, 0, t_acc);

        // randomized mix
        for (int n = 0; n < 40; n++) begin
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(0, 2));
            bresp_cfg = ($urandom_range(0, 3) == 0) ? AXI_ERR : AXI_OK;
            rresp_cfg = ($urandom_range(0, 3) == 0) ? AXI_ERR : AXI_OK;
            do_cmd($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7) * 4), $urandom,
                   $urandom_range(0, 2), t_acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
